// File: rtl/vga_colproc_pkg.sv
// Shared colour-depth encodings, FSM state codes and per-phase word bookkeeping
// for the colour processor.
package vga_colproc_pkg;

   typedef logic [1:0] cd_t;

   localparam cd_t CD_8  = 2'b00;
   localparam cd_t CD_16 = 2'b01;
   localparam cd_t CD_24 = 2'b10;
   localparam cd_t CD_32 = 2'b11;

   localparam logic [1:0] S_WORD = 2'd0;
   localparam logic [1:0] S_PIX  = 2'd1;
   localparam logic [1:0] S_CLUT = 2'd2;

   // 24bpp: phases 0..2 each start on a fresh word, phase 3 finishes the third word
   function automatic logic needs_word_f(input cd_t cd, input logic [1:0] phase);
      case (cd)
         CD_8, CD_16: return (phase == 2'd0);
         CD_24:       return (phase != 2'd3);
         default:     return 1'b1;
      endcase
   endfunction

   function automatic logic last_pixel_f(input cd_t cd, input logic [1:0] phase);
      case (cd)
         CD_8:    return (phase == 2'd3);
         CD_16:   return (phase == 2'd1);
         CD_24:   return (phase == 2'd3);
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/vga_colproc_unpack.sv
// Combinational pixel extraction and colour expansion for one unpack phase.
module vga_colproc_unpack
   import vga_colproc_pkg::*;
(
   input  logic [31:0] word,
   input  logic [15:0] resid,
   input  logic [1:0]  phase,
   input  cd_t         cd,
   input  logic        pc,
   output logic [23:0] rgb,
   output logic [7:0]  clut_idx,
   output logic        last_pixel,
   output logic        needs_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      case (phase)
         2'd0:    byte_sel = word[31:24];
         2'd1:    byte_sel = word[23:16];
         2'd2:    byte_sel = word[15:8];
         default: byte_sel = word[7:0];
      endcase
      half_sel = phase[0] ? word[15:0] : word[31:16];

      rgb = 24'h0;
      case (cd)
         CD_8:  rgb = pc ? 24'h0 : {3{byte_sel}};
         CD_16: rgb = {half_sel[15:11], half_sel[15:13],
                       half_sel[10:5],  half_sel[10:9],
                       half_sel[4:0],   half_sel[4:2]};
         // residual holds the tail bytes of the previous word
         CD_24: begin
            case (phase)
               2'd0:    rgb = word[31:8];
               2'd1:    rgb = {resid[7:0], word[31:16]};
               2'd2:    rgb = {resid, word[31:24]};
               default: rgb = word[23:0];
            endcase
         end
         default: rgb = word[23:0];
      endcase
   end

   assign clut_idx   = byte_sel;
   assign last_pixel = last_pixel_f(cd, phase);
   assign needs_word = needs_word_f(cd, phase);

endmodule

// File: rtl/vga_colproc.sv
// Colour processor: unpacks video words into RGB pixels for the line FIFO,
// with optional CLUT lookup in 8bpp pseudo-colour mode.
module vga_colproc
   import vga_colproc_pkg::*;
(
   input  logic        clk_i,
   input  logic        nrst_i,
   input  logic        ctrl_ven,
   input  logic [1:0]  ctrl_cd,
   input  logic        ctrl_pc,
   input  logic        clut_bank_i,
   input  logic [31:0] vdat_i,
   input  logic        vdat_empty_i,
   output logic        vdat_rreq_o,
   output logic        clut_req_o,
   output logic [8:0]  clut_adr_o,
   input  logic        clut_ack_i,
   input  logic [23:0] clut_q_i,
   output logic [23:0] rgb_o,
   output logic        rgb_we_o,
   input  logic        lf_full_i
);

   logic [1:0]  state_reg, state_next;
   logic [1:0]  phase_reg, phase_next;
   logic [31:0] word_reg, word_next;
   logic [15:0] resid_reg, resid_next;
   logic [23:0] pix_reg, pix_next;
   logic        pix_valid_reg, pix_valid_next;
   logic [8:0]  clut_adr_reg, clut_adr_next;
   cd_t         cd_reg, cd_next;
   logic        pc_reg, pc_next;
   logic        ven_d_reg;

   logic        enable, pix_free, need_word, avail, step, use_clut, last_pixel;
   logic [31:0] word_cur;
   logic [23:0] unpack_rgb;
   logic [7:0]  clut_idx;
   logic [1:0]  phase_adv;

   vga_colproc_unpack u_unpack (
      .word       (word_cur),
      .resid      (resid_reg),
      .phase      (phase_reg),
      .cd         (cd_reg),
      .pc         (pc_reg),
      .rgb        (unpack_rgb),
      .clut_idx   (clut_idx),
      .last_pixel (last_pixel),
      .needs_word (need_word)
   );

   // the first enabled cycle only latches the mode, so no work starts on stale cd/pc
   assign enable    = ctrl_ven & ven_d_reg;
   assign pix_free  = ~pix_valid_reg | ~lf_full_i;
   assign word_cur  = need_word ? vdat_i : word_reg;
   assign avail     = ~need_word | ~vdat_empty_i;
   assign step      = enable & (state_reg != S_CLUT) & pix_free & avail;
   assign use_clut  = (cd_reg == CD_8) & pc_reg;
   assign phase_adv = last_pixel ? 2'd0 : 2'(phase_reg + 2'd1);

   assign rgb_we_o    = pix_valid_reg & ~lf_full_i;
   assign vdat_rreq_o = step & need_word;
   assign clut_req_o  = (state_reg == S_CLUT);
   assign clut_adr_o  = clut_adr_reg;
   assign rgb_o       = pix_reg;

   always_comb begin
      state_next     = state_reg;
      phase_next     = phase_reg;
      word_next      = word_reg;
      resid_next     = resid_reg;
      pix_next       = pix_reg;
      pix_valid_next = pix_valid_reg & ~rgb_we_o;
      clut_adr_next  = clut_adr_reg;
      cd_next        = cd_reg;
      pc_next        = pc_reg;

      if (ctrl_ven & ~ven_d_reg) begin
         cd_next = ctrl_cd;
         pc_next = ctrl_pc;
      end

      if (step) begin
         phase_next = phase_adv;
         if (need_word) begin
            word_next  = vdat_i;
            resid_next = vdat_i[15:0];
         end
         if (use_clut) begin
            state_next    = S_CLUT;
            clut_adr_next = {clut_bank_i, clut_idx};
         end else begin
            pix_next       = unpack_rgb;
            pix_valid_next = 1'b1;
            state_next     = needs_word_f(cd_reg, phase_adv) ? S_WORD : S_PIX;
         end
      end else if (enable && (state_reg == S_CLUT) && clut_ack_i) begin
         // register is guaranteed free here: launch required it free
         pix_next       = clut_q_i;
         pix_valid_next = 1'b1;
         state_next     = needs_word_f(cd_reg, phase_reg) ? S_WORD : S_PIX;
      end

      if (!ctrl_ven) begin
         state_next     = S_WORD;
         phase_next     = 2'd0;
         word_next      = 32'h0;
         resid_next     = 16'h0;
         pix_next       = 24'h0;
         pix_valid_next = 1'b0;
         clut_adr_next  = 9'h0;
      end
   end

   always_ff @(posedge clk_i or negedge nrst_i) begin
      if (!nrst_i) begin
         state_reg     <= S_WORD;
         phase_reg     <= 2'd0;
         word_reg      <= 32'h0;
         resid_reg     <= 16'h0;
         pix_reg       <= 24'h0;
         pix_valid_reg <= 1'b0;
         clut_adr_reg  <= 9'h0;
         cd_reg        <= CD_8;
         pc_reg        <= 1'b0;
         ven_d_reg     <= 1'b0;
      end else begin
         state_reg     <= state_next;
         phase_reg     <= phase_next;
         word_reg      <= word_next;
         resid_reg     <= resid_next;
         pix_reg       <= pix_next;
         pix_valid_reg <= pix_valid_next;
         clut_adr_reg  <= clut_adr_next;
         cd_reg        <= cd_next;
         pc_reg        <= pc_next;
         ven_d_reg     <= ctrl_ven;
      end
   end

endmodule

// File: tb/tb_vga_colproc.sv
// Self-checking bench: word-buffer and CLUT responders, a byte-stream pixel
// model, and a per-cycle compare of every line-FIFO write.
module tb_vga_colproc;

   logic        clk_i, nrst_i, ctrl_ven, ctrl_pc, clut_bank_i;
   logic [1:0]  ctrl_cd;
   logic [31:0] vdat_i;
   logic        vdat_empty_i, vdat_rreq_o;
   logic        clut_req_o, clut_ack_i;
   logic [8:0]  clut_adr_o;
   logic [23:0] clut_q_i, rgb_o;
   logic        rgb_we_o, lf_full_i;

   vga_colproc dut (
      .clk_i        (clk_i),
      .nrst_i       (nrst_i),
      .ctrl_ven     (ctrl_ven),
      .ctrl_cd      (ctrl_cd),
      .ctrl_pc      (ctrl_pc),
      .clut_bank_i  (clut_bank_i),
      .vdat_i       (vdat_i),
      .vdat_empty_i (vdat_empty_i),
      .vdat_rreq_o  (vdat_rreq_o),
      .clut_req_o   (clut_req_o),
      .clut_adr_o   (clut_adr_o),
      .clut_ack_i   (clut_ack_i),
      .clut_q_i     (clut_q_i),
      .rgb_o        (rgb_o),
      .rgb_we_o     (rgb_we_o),
      .lf_full_i    (lf_full_i)
   );

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int ack_delay = 3;

   logic [31:0] wq[$];
   logic [23:0] exp_q[$];
   logic [7:0]  bq[$];
   logic [23:0] got_log[$];
   int          wr_log[$], pop_log[$], ack_log[$];
   logic [8:0]  adr_log[$];
   logic [23:0] clut_mem [512];
   logic [1:0]  m_cd;
   logic        m_pc, m_bank;
   logic [8:0]  held_adr;

   initial begin
      clk_i = 1'b0;
      forever #5 clk_i = ~clk_i;
   end

   initial forever begin
      @(posedge clk_i);
      cyc++;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] got_at(input int i);
      return (got_log.size() > i) ? {8'h0, got_log[i]} : 32'hDEAD_BEEF;
   endfunction

   function automatic int wr_at(input int i);
      return (wr_log.size() > i) ? wr_log[i] : -100;
   endfunction

   // Model: what pixels this word must eventually produce, in order
   task automatic push_word(input logic [31:0] w);
      logic [15:0] h;
      logic [7:0]  b;
      int r5, g6, b5;
      wq.push_back(w);
      case (m_cd)
         2'b00: for (int i = 3; i >= 0; i--) begin
            b = w[8*i +: 8];
            exp_q.push_back(m_pc ? clut_mem[{m_bank, b}] : {b, b, b});
         end
         2'b01: for (int i = 1; i >= 0; i--) begin
            h  = w[16*i +: 16];
            r5 = int'(h) / 2048;
            g6 = (int'(h) / 32) % 64;
            b5 = int'(h) % 32;
            exp_q.push_back({8'((r5 * 8) + (r5 / 4)), 8'((g6 * 4) + (g6 / 16)), 8'((b5 * 8) + (b5 / 4))});
         end
         2'b10: begin
            for (int i = 3; i >= 0; i--) bq.push_back(w[8*i +: 8]);
            while (bq.size() >= 3) begin
               exp_q.push_back({bq[0], bq[1], bq[2]});
               repeat (3) void'(bq.pop_front());
            end
         end
         default: exp_q.push_back(w[23:0]);
      endcase
   endtask

   // Word buffer: show-ahead queue, popped on the cycle rreq is high
   initial begin
      logic do_pop;
      vdat_i = 32'h0;
      vdat_empty_i = 1'b1;
      forever begin
         @(negedge clk_i);
         do_pop = vdat_rreq_o;
         if (vdat_rreq_o) begin
            check("rreq_not_empty", {31'h0, vdat_empty_i}, 32'h0);
            pop_log.push_back(cyc);
         end
         @(posedge clk_i);
         #2;
         if (do_pop && wq.size() > 0) void'(wq.pop_front());
         if (wq.size() > 0) begin
            vdat_i = wq[0];
            vdat_empty_i = 1'b0;
         end else begin
            vdat_empty_i = 1'b1;
         end
      end
   end

   // CLUT responder: acks ack_delay cycles after a request appears
   initial begin
      int cnt;
      cnt = 0;
      clut_ack_i = 1'b0;
      clut_q_i = 24'h0;
      held_adr = 9'h0;
      forever begin
         @(negedge clk_i);
         if (clut_req_o && !clut_ack_i) begin
            if (cnt == 0) held_adr = clut_adr_o;
            else check("clut_adr_stable", {23'h0, clut_adr_o}, {23'h0, held_adr});
            cnt++;
         end else begin
            cnt = 0;
         end
         @(posedge clk_i);
         #1;
         if (clut_ack_i) begin
            clut_ack_i = 1'b0;
         end else if (cnt != 0 && cnt >= ack_delay) begin
            clut_ack_i = 1'b1;
            clut_q_i = clut_mem[held_adr];
            ack_log.push_back(cyc);
            adr_log.push_back(held_adr);
         end
      end
   end

   // Compare every line-FIFO write against the model
   initial forever begin
      @(negedge clk_i);
      if (lf_full_i) check("we_while_full", {31'h0, rgb_we_o}, 32'h0);
      if (rgb_we_o) begin
         got_log.push_back(rgb_o);
         wr_log.push_back(cyc);
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL pixel_unexpected: got %0h want none", rgb_o);
         end else begin
            logic [23:0] e;
            e = exp_q.pop_front();
            if (rgb_o !== e) begin
               bad++;
               $display("FAIL pixel: got %0h want %0h", rgb_o, e);
            end
            $display("pixel %06h at cycle %0d", rgb_o, cyc);
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic clear_model();
      wq.delete(); exp_q.delete(); bq.delete();
   endtask

   task automatic start(input logic [1:0] cd, input logic pc);
      ctrl_ven = 1'b0;
      clear_model();
      @(posedge clk_i); #1;
      ctrl_cd = cd; ctrl_pc = pc; m_cd = cd; m_pc = pc;
      ctrl_ven = 1'b1;
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      got_log.delete(); wr_log.delete(); pop_log.delete(); ack_log.delete(); adr_log.delete();
   endtask

   task automatic wait_drain(input string name, input int budget);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || wq.size() != 0) && k < budget) begin
         @(posedge clk_i); #1;
         k++;
      end
      @(posedge clk_i); #1;
      check(name, 32'(exp_q.size() + wq.size()), 32'h0);
   endtask

   task automatic outs_zero(input string name);
      check({name, "_rgb"}, {8'h0, rgb_o}, 32'h0);
      check({name, "_ctl"}, {20'h0, rgb_we_o, clut_req_o, clut_adr_o, vdat_rreq_o}, 32'h0);
   endtask

   initial begin
      int k;
      for (int i = 0; i < 512; i++) clut_mem[i] = 24'((i * 24'h010307) ^ 24'h5A0000);
      clut_mem[9'h105] = 24'hABCDEF;
      nrst_i = 1'b0; ctrl_ven = 1'b0; ctrl_cd = 2'b00; ctrl_pc = 1'b0;
      clut_bank_i = 1'b0; lf_full_i = 1'b0;
      m_cd = 2'b00; m_pc = 1'b0; m_bank = 1'b0;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      outs_zero("reset_state");
      @(posedge clk_i); #1;
      nrst_i = 1'b1;

      // 32bpp, mode change while enabled must be ignored
      start(2'b11, 1'b0);
      ctrl_cd = 2'b00;
      push_word(32'h0011_2233);
      push_word(32'hFF44_5566);
      wait_drain("t1_drain", 50);
      check("t1_px0", got_at(0), 32'h112233);
      check("t1_px1", got_at(1), 32'h445566);
      check("t1_latency", 32'(wr_at(0)), 32'((pop_log.size() > 0 ? pop_log[0] : -50) + 1));
      check("t1_back_to_back", 32'(wr_at(1)), 32'(wr_at(0) + 1));

      // 24bpp, four pixels from three words
      start(2'b10, 1'b0);
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
      push_word(32'h99AA_BBCC);
      wait_drain("t2_drain", 50);
      check("t2_px0", got_at(0), 32'h112233);
      check("t2_px1", got_at(1), 32'h445566);
      check("t2_px2", got_at(2), 32'h778899);
      check("t2_px3", got_at(3), 32'hAABBCC);

      // 16bpp 565 and 8bpp greyscale
      start(2'b01, 1'b0);
      push_word(32'hF800_001F);
      wait_drain("t3a_drain", 50);
      check("t3_565_px0", got_at(0), 32'hFF0000);
      check("t3_565_px1", got_at(1), 32'h0000FF);
      start(2'b00, 1'b0);
      push_word(32'h80FF_0001);
      wait_drain("t3b_drain", 50);
      check("t3_grey_px0", got_at(0), 32'h808080);
      check("t3_grey_px1", got_at(1), 32'hFFFFFF);
      check("t3_grey_px2", got_at(2), 32'h000000);
      check("t3_grey_px3", got_at(3), 32'h010101);

      // 8bpp pseudo-colour, bank 1, ack three clocks after request
      clut_bank_i = 1'b1; m_bank = 1'b1; ack_delay = 3;
      start(2'b00, 1'b1);
      push_word(32'h0500_0000);
      wait_drain("t4_drain", 100);
      check("t4_adr", (adr_log.size() > 0) ? {23'h0, adr_log[0]} : 32'hDEAD_BEEF, 32'h105);
      check("t4_px0", got_at(0), 32'hABCDEF);
      check("t4_ack_to_we", 32'(wr_at(0)), 32'((ack_log.size() > 0 ? ack_log[0] : -50) + 1));

      // line FIFO full for 5 clocks mid-word
      start(2'b00, 1'b0);
      push_word(32'h0102_0304);
      push_word(32'h0506_0708);
      k = 0;
      while (got_log.size() < 2 && k < 20) begin @(posedge clk_i); #1; k++; end
      lf_full_i = 1'b1;
      k = pop_log.size();
      repeat (5) @(posedge clk_i);
      #1;
      check("t5_no_pop_while_full", 32'(pop_log.size()), 32'(k));
      lf_full_i = 1'b0;
      wait_drain("t5_drain", 50);
      check("t5_count", 32'(got_log.size()), 32'd8);
      check("t5_px2", got_at(2), 32'h030303);

      // flush while a CLUT request is outstanding
      ack_delay = 20;
      start(2'b00, 1'b1);
      push_word(32'h0506_0708);
      k = 0;
      while (!clut_req_o && k < 20) begin @(posedge clk_i); #1; k++; end
      check("t6_clut_req_seen", {31'h0, clut_req_o}, 32'h1);
      ctrl_ven = 1'b0;
      clear_model();
      @(posedge clk_i);
      @(negedge clk_i);
      outs_zero("t6_flush_clut");
      ack_delay = 3;

      // flush in 24bpp phase 2, then re-enable in 32bpp
      start(2'b10, 1'b0);
      push_word(32'h1122_3344);
      push_word(32'h5566_7788);
      wait_drain("t6b_drain", 50);
      ctrl_ven = 1'b0;
      clear_model();
      @(posedge clk_i);
      @(negedge clk_i);
      outs_zero("t6_flush_24");
      start(2'b11, 1'b0);
      push_word(32'hAA01_0203);
      wait_drain("t6c_drain", 50);
      check("t6_reenable_px0", got_at(0), 32'h010203);

      // async reset mid-burst, then 24bpp restarts at phase 0
      start(2'b01, 1'b0);
      push_word(32'h1234_5678);
      push_word(32'h9ABC_DEF0);
      push_word(32'h0F0F_F0F0);
      @(posedge clk_i); #3;
      nrst_i = 1'b0;
      clear_model();
      #1;
      outs_zero("t6_async_reset");
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      nrst_i = 1'b1;
      start(2'b10, 1'b0);
      push_word(32'h0001_0203);
      push_word(32'h0405_0607);
      push_word(32'h0809_0A0B);
      wait_drain("t6d_drain", 50);
      check("t6_restart_px0", got_at(0), 32'h000102);
      check("t6_restart_px1", got_at(1), 32'h030405);
      check("t6_restart_px2", got_at(2), 32'h060708);
      check("t6_restart_px3", got_at(3), 32'h090A0B);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
